ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite subordinate that answers the transfers issued by the team's AHB master.
//  Backs an on-chip word-organised memory of 2**ADDR_BITS bytes.
//  Supports a programmable wait-state count and the two-cycle ERROR response.
//  HSEL comes from the external address decoder; HREADY is the muxed bus ready.
// PARAMETERS
//  ADDR_BITS    10  byte-address bits decoded locally; memory depth = 2**(ADDR_BITS-2) words
//  WAIT_STATES   1  wait cycles (HREADYOUT=0) inserted in every OKAY data phase; range 0..15
// PORTS
//  HCLK       in   1   bus clock; all state updates on rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select (address phase)
//  HADDR      in   32  byte address; only HADDR[ADDR_BITS-1:0] used
//  HWRITE     in   1   1=write, 0=read
//  HSIZE      in   3   000 byte, 001 halfword, 010 word; others are errors
//  HBURST     in   3   ignored: every beat is handled as an independent transfer
//  HPROT      in   4   ignored
//  HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HMASTLOCK  in   1   ignored
//  HREADY     in   1   bus ready; an address phase is sampled only when high
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data (valid in final read data-phase cycle)
//  HREADYOUT  out  1   slave ready
//  HRESP      out  1   0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset (async, HRESETn=0):
//   - HREADYOUT=1, HRESP=0, HRDATA=0; FSM enters ST_IDLE; wait counter=0; pending transfer discarded.
//   - Memory array is not reset.
//   - Reset during a data phase aborts the transfer; no memory write occurs.
//  Accept:
//   - An address phase is accepted when HSEL & HREADY & HTRANS[1] at a rising edge.
//   - On acceptance, latch addr, write, size, and the error flag.
//   - IDLE/BUSY, HSEL=0, or HREADY=0: nothing is latched; the next cycle is a zero-wait OKAY.
//  Error flag:
//   - Set when HSIZE>010.
//   - Set on misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
//  FSM states:
//   ST_IDLE: HREADYOUT=1, HRESP=0.
//     - Accept with error flag -> ST_ERR1.
//     - Accept, no error, WAIT_STATES>0 -> ST_WAIT with count=WAIT_STATES.
//     - Accept, no error, WAIT_STATES=0 -> ST_DATA.
//   ST_WAIT: HREADYOUT=0, HRESP=0.
//     - Decrement count each cycle; count==1 -> ST_DATA.
//     - Address-phase inputs are ignored while here.
//   ST_DATA: final cycle; HREADYOUT=1, HRESP=0.
//     - Read: HRDATA = mem[addr[ADDR_BITS-1:2]], full word on all lanes.
//     - Write: at the closing edge, write HWDATA byte lanes (little-endian).
//       Byte lane = addr[1:0]; halfword lanes = addr[1]*2 +{0,1}; word = all 4.
//     - The same edge may accept a new address phase (pipelined) -> ST_ERR1, ST_WAIT or ST_DATA.
//     - Otherwise -> ST_IDLE.
//   ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
//   ST_ERR2: HREADYOUT=1, HRESP=1.
//     - New accept is allowed (same rules as ST_DATA); otherwise -> ST_IDLE.
//     - An errored transfer never writes memory.
//  Data rules:
//   - HRDATA=0 in every cycle except ST_DATA of a read.
//   - Write-then-read to the same word returns the new data; no hazard, because the write lands at the end of the write data phase.
//  Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
// TESTING
//  T1 reset: HRESETn=0 mid-ST_WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; prior write not committed.
//  T2 WAIT_STATES=1: NONSEQ word write 0x10=0xDEADBEEF, then read 0x10 -> HREADYOUT low 1 cycle each; HRDATA=0xDEADBEEF.
//  T3 byte write 0xA5 @0x13 over word 0x11223344 @0x10 -> read 0x10 returns 0xA5223344.
//  T4 halfword write HSIZE=001 @0x21 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; mem @0x20 unchanged.
//  T5 WAIT_STATES=0: back-to-back SEQ word writes 0x0,0x4,0x8,0xC then reads -> no wait cycles, data correct, pipelined accept.
//  T6 HSEL=0, or HTRANS=BUSY/IDLE, or HREADY=0 with HTRANS=NONSEQ -> no state change, HREADYOUT=1, HRESP=0, no write.

Source files
------------

// File: rtl/ahb_sram_if.sv
// AHB-Lite bus bundle between the master/decoder side and one SRAM subordinate.
// HREADY is the muxed bus ready; HREADYOUT is this subordinate's own ready.
`timescale 1ns/1ps
interface ahb_sram_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backed by a word-organised on-chip SRAM, with a fixed
// number of wait states per OKAY data phase and the two-cycle ERROR response.
`timescale 1ns/1ps
module ahb_sram_slave #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 1
) (
   input logic       HCLK,
   input logic       HRESETn,
   ahb_sram_if.slave bus
);
   localparam int DEPTH = 2 ** (ADDR_BITS - 2);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   addr_q;
   logic                   write_q;
   logic [1:0]             size_q;
   logic [31:0]            mem [DEPTH];
   logic                   accept;
   logic                   size_err;
   logic [3:0]             lane_en;
   logic                   unused_ok;

   assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR[31:ADDR_BITS]};

   // Only states that present HREADYOUT=1 close a data phase and may take a new address.
   assign accept = (state_q inside {ST_IDLE, ST_DATA, ST_ERR2})
                   & bus.HSEL & bus.HREADY & bus.HTRANS[1];

   // NOTE: every variable assigned in an always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      size_err = 1'b1;
      case (bus.HSIZE)
         3'b000:  size_err = 1'b0;
         3'b001:  size_err = bus.HADDR[0];
         3'b010:  size_err = |bus.HADDR[1:0];
         default: size_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_DATA;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               if (size_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= bus.HADDR[ADDR_BITS-1:0];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE[1:0];
         end
      end
   end

   // Little-endian lane enables; errored sizes never reach ST_DATA.
   always_comb begin
      lane_en = 4'b1111;
      case (size_q)
         2'b00:   lane_en = 4'b0001 << addr_q[1:0];
         2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // NOTE: the memory array has no reset; reset forces ST_IDLE, which alone blocks a pending write.
   always_ff @(posedge HCLK) begin
      if (state_q == ST_DATA && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) mem[addr_q[ADDR_BITS-1:2]][8*b +: 8] <= bus.HWDATA[8*b +: 8];
         end
      end
   end

   assign bus.HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
   assign bus.HRESP     = state_q inside {ST_ERR1, ST_ERR2};
   assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? mem[addr_q[ADDR_BITS-1:2]] : '0;
endmodule
